// File: rtl/vmask_accum.sv
// vmask_accum: write-combining stage that merges successive mask-compare beats
// to the same destination address into one register image.
// Latency: a beat accepted with in_last at edge N shows up on out_* from cycle N+1.
// Backpressure: the single-entry output slot stalls in_ready only for beats that
// would write the slot. An address mismatch that carries in_last costs one
// self-flush cycle before the beat is taken.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready             input beat handshake
//   in_addr, in_vec, in_bit_en    destination address, positioned mask bits, per-bit enables
//   in_last                       final beat for this destination
//   out_valid/out_ready           output slot handshake
//   out_addr, out_vec, out_bit_en merged image (bits that were never enabled read 0)
//   out_be                        byte enables folded from out_bit_en
//   out_beats                     number of beats merged (saturating)
module vmask_accum #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_vec,
  input  logic [DATA_WIDTH-1:0] in_bit_en,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_vec,
  output logic [DATA_WIDTH-1:0] out_bit_en,
  output logic [BE_WIDTH-1:0]   out_be,
  output logic [CNT_WIDTH-1:0]  out_beats
);

  // Accumulator state
  logic                  acc_active;
  logic [DATA_WIDTH-1:0] acc_vec;
  logic [DATA_WIDTH-1:0] acc_en;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [CNT_WIDTH-1:0]  acc_cnt;

  logic                  slot_free;
  logic                  addr_match;
  logic                  addr_miss;
  logic                  accept;
  logic                  self_flush;
  logic                  flush;
  logic                  flush_old;

  // Accumulator contents after the current beat is absorbed
  logic [DATA_WIDTH-1:0] nxt_vec;
  logic [DATA_WIDTH-1:0] nxt_en;
  logic [CNT_WIDTH-1:0]  nxt_cnt;

  // Image written to the output slot this cycle (when flush is set)
  logic [ADDR_WIDTH-1:0] flush_addr;
  logic [DATA_WIDTH-1:0] flush_vec;
  logic [DATA_WIDTH-1:0] flush_en;
  logic [CNT_WIDTH-1:0]  flush_cnt;
  logic [BE_WIDTH-1:0]   flush_be;

  assign slot_free  = !out_valid || out_ready;
  assign addr_match = acc_active && (in_addr == acc_addr);
  assign addr_miss  = acc_active && (in_addr != acc_addr);

  // A mismatching beat with in_last would need two slot writes (old acc and the
  // new single-beat image) in one cycle. Refuse it and flush the old acc instead;
  // the beat is then taken as an idle-case beat on a later cycle.
  always_comb begin
    in_ready = 1'b1;
    if (addr_miss && in_last) begin
      in_ready = 1'b0;
    end else if (addr_miss || in_last) begin
      in_ready = slot_free;
    end
  end

  assign accept     = in_valid && in_ready;
  assign self_flush = in_valid && addr_miss && in_last && slot_free;
  // The old acc goes out on a self-flush, or when a non-last beat to a new address is accepted.
  assign flush_old  = self_flush || (accept && addr_miss);
  assign flush      = flush_old || (accept && in_last);

  always_comb begin
    if (addr_match) begin
      nxt_vec = (acc_vec & ~in_bit_en) | (in_vec & in_bit_en);
      nxt_en  = acc_en | in_bit_en;
      nxt_cnt = (acc_cnt == {CNT_WIDTH{1'b1}}) ? acc_cnt : acc_cnt + CNT_WIDTH'(1);
    end else begin
      nxt_vec = in_vec & in_bit_en;
      nxt_en  = in_bit_en;
      nxt_cnt = CNT_WIDTH'(1);
    end
  end

  always_comb begin
    if (flush_old) begin
      flush_addr = acc_addr;
      flush_vec  = acc_vec;
      flush_en   = acc_en;
      flush_cnt  = acc_cnt;
    end else begin
      flush_addr = in_addr;
      flush_vec  = nxt_vec;
      flush_en   = nxt_en;
      flush_cnt  = nxt_cnt;
    end
    flush_be = '0;
    for (int k = 0; k < BE_WIDTH; k++) begin
      flush_be[k] = |flush_en[8*k +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_active <= 1'b0;
      acc_vec    <= '0;
      acc_en     <= '0;
      acc_addr   <= '0;
      acc_cnt    <= '0;
    end else if (accept) begin
      acc_active <= !in_last;
      acc_vec    <= nxt_vec;
      acc_en     <= nxt_en;
      acc_addr   <= in_addr;
      acc_cnt    <= nxt_cnt;
    end else if (self_flush) begin
      acc_active <= 1'b0;
    end
  end

  // Output slot: only loaded by a flush, and a flush is only possible when the
  // slot is free, so the contents hold while out_valid & !out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_addr   <= '0;
      out_vec    <= '0;
      out_bit_en <= '0;
      out_be     <= '0;
      out_beats  <= '0;
    end else if (flush) begin
      out_valid  <= 1'b1;
      out_addr   <= flush_addr;
      out_vec    <= flush_vec;
      out_bit_en <= flush_en;
      out_be     <= flush_be;
      out_beats  <= flush_cnt;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vmask_accum.sv
// tb_vmask_accum: directed-vector bench for vmask_accum with hand-computed
// expected images, single-beat-per-cycle stimulus, and a one-line summary.
module tb_vmask_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [63:0] in_vec;
  logic [63:0] in_bit_en;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [63:0] out_vec;
  logic [63:0] out_bit_en;
  logic [7:0]  out_be;
  logic [7:0]  out_beats;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vmask_accum dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_addr    (in_addr),
    .in_vec     (in_vec),
    .in_bit_en  (in_bit_en),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_vec    (out_vec),
    .out_bit_en (out_bit_en),
    .out_be     (out_be),
    .out_beats  (out_beats)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a beat, then let combinational in_ready settle before sampling.
  task automatic drive(input logic [31:0] a, input logic [63:0] v,
                       input logic [63:0] e, input logic l);
    in_valid  = 1'b1;
    in_addr   = a;
    in_vec    = v;
    in_bit_en = e;
    in_last   = l;
    #1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_addr   = '0;
    in_vec    = '0;
    in_bit_en = '0;
    #1;
  endtask

  task automatic check_img(input string tag, input logic [31:0] a, input logic [63:0] v,
                           input logic [63:0] e, input logic [7:0] be, input logic [7:0] n);
    check({tag, ".valid"}, 64'(out_valid), 64'h1);
    check({tag, ".addr"},  64'(out_addr),  64'(a));
    check({tag, ".vec"},   out_vec,        v);
    check({tag, ".en"},    out_bit_en,     e);
    check({tag, ".be"},    64'(out_be),    64'(be));
    check({tag, ".beats"}, 64'(out_beats), 64'(n));
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b1;
    idle();
    tick();
    tick();
    // Reset state
    check("rst.valid", 64'(out_valid),  64'h0);
    check("rst.addr",  64'(out_addr),   64'h0);
    check("rst.vec",   out_vec,         64'h0);
    check("rst.en",    out_bit_en,      64'h0);
    check("rst.be",    64'(out_be),     64'h0);
    check("rst.beats", 64'(out_beats),  64'h0);
    check("rst.rdy",   64'(in_ready),   64'h1);
    rst = 1'b0;
    tick();

    // 1: four 16-bit chunks merged into one full word
    for (int k = 0; k < 4; k++) begin
      drive(32'h10, 64'hAAAA << (16 * k), 64'hFFFF << (16 * k), k == 3);
      check($sformatf("t1.rdy%0d", k), 64'(in_ready), 64'h1);
      tick();
      if (k < 3) check($sformatf("t1.early%0d", k), 64'(out_valid), 64'h0);
    end
    check_img("t1", 32'h10, 64'hAAAAAAAAAAAAAAAA, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 8'd4);
    idle();
    tick();
    check("t1.drain", 64'(out_valid), 64'h0);

    // 2: address change carrying in_last -> self-flush, one stall cycle
    drive(32'h10, 64'h0F, 64'hFF, 1'b0);
    check("t2.rdy0", 64'(in_ready), 64'h1);
    tick();
    check("t2.novld", 64'(out_valid), 64'h0);
    drive(32'h20, 64'h3300, 64'hFF00, 1'b1);
    check("t2.stall", 64'(in_ready), 64'h0);
    tick();
    check_img("t2a", 32'h10, 64'h0F, 64'hFF, 8'h01, 8'd1);
    check("t2.rdy1", 64'(in_ready), 64'h1);
    tick();
    check_img("t2b", 32'h20, 64'h3300, 64'hFF00, 8'h02, 8'd1);
    idle();
    tick();
    check("t2.drain", 64'(out_valid), 64'h0);

    // 3: slot held by a stalled consumer
    out_ready = 1'b0;
    drive(32'h40, 64'h1, 64'h1, 1'b1);
    check("t3.rdy0", 64'(in_ready), 64'h1);
    tick();
    check_img("t3a", 32'h40, 64'h1, 64'h1, 8'h01, 8'd1);
    drive(32'h30, 64'h3, 64'h3, 1'b1);
    check("t3.blk", 64'(in_ready), 64'h0);
    tick();
    tick();
    check_img("t3hold", 32'h40, 64'h1, 64'h1, 8'h01, 8'd1);
    check("t3.blk2", 64'(in_ready), 64'h0);
    out_ready = 1'b1;
    #1;
    check("t3.rdy1", 64'(in_ready), 64'h1);
    tick();
    check_img("t3b", 32'h30, 64'h3, 64'h3, 8'h01, 8'd1);
    idle();
    tick();
    check("t3.drain", 64'(out_valid), 64'h0);

    // 4: overlapping enables, later beat wins on overlap: (5&~C)|(8&C) = 9
    drive(32'h50, 64'h5, 64'hF, 1'b0);
    tick();
    drive(32'h50, 64'h8, 64'hC, 1'b1);
    check("t4.rdy", 64'(in_ready), 64'h1);
    tick();
    check_img("t4", 32'h50, 64'h9, 64'hF, 8'h01, 8'd2);

    // 5: back-to-back last beats and a zero-enable beat at full rate
    drive(32'h90, 64'hFF, 64'hFF, 1'b1);
    check("t5.rdy0", 64'(in_ready), 64'h1);
    tick();
    check_img("t5a", 32'h90, 64'hFF, 64'hFF, 8'h01, 8'd1);
    drive(32'h91, 64'hFFFF_0000_0000_0000, 64'h0, 1'b1);
    check("t5.rdy1", 64'(in_ready), 64'h1);
    tick();
    check_img("t5b", 32'h91, 64'h0, 64'h0, 8'h00, 8'd1);
    idle();
    tick();

    // 6: reset mid-merge with a pending slot discards both
    out_ready = 1'b0;
    drive(32'h70, 64'hFF, 64'hFF, 1'b1);
    tick();
    check("t6.pend", 64'(out_valid), 64'h1);
    drive(32'h60, 64'h1, 64'h1, 1'b0);
    check("t6.rdy0", 64'(in_ready), 64'h1);
    tick();
    drive(32'h60, 64'h2, 64'h2, 1'b0);
    check("t6.rdy1", 64'(in_ready), 64'h1);
    tick();
    rst = 1'b1;
    idle();
    tick();
    check("t6.valid", 64'(out_valid), 64'h0);
    check("t6.addr",  64'(out_addr),  64'h0);
    check("t6.vec",   out_vec,        64'h0);
    check("t6.beats", 64'(out_beats), 64'h0);
    check("t6.rdy",   64'(in_ready),  64'h1);
    rst = 1'b0;
    out_ready = 1'b1;
    drive(32'h60, 64'h4, 64'h4, 1'b1);
    check("t6.rdy2", 64'(in_ready), 64'h1);
    tick();
    check_img("t6", 32'h60, 64'h4, 64'h4, 8'h01, 8'd1);
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
